// File: rtl/axi_sram_rd_pipe.sv
// axi_sram_rd_pipe: SRAM read-return stage. A fixed-latency tag pipeline
// captures the selected row's bank data into a FWFT beat buffer that feeds
// an AXI-style R channel; a credit counter reserves a buffer slot per read.
// Ports: clk_i, rst_ni (sync, active-low); issue_valid_i/issue_ready_o,
// issue_row_i, issue_id_i, issue_last_i start a read; bank_rdata_i is the
// raw bank data; r_valid_o/r_ready_i, r_data_o, r_id_o, r_last_o, r_resp_o
// form the R beat; credits_o shows free slots.
// Option AXI_SRAM_RD_PIPE_PARITY_EN adds bank_rpar_i (even parity per
// bank word); a mismatch at capture returns SLVERR with that beat.
module axi_sram_rd_pipe #(
  parameter int SRAM_BANKS_ROWS      = 1,
  parameter int SRAM_BANKS_COLS      = 1,
  parameter int SRAM_BANK_DATA_WIDTH = 32,
  parameter int SRAM_READ_LATENCY    = 2,
  parameter int AXI_ID_WIDTH         = 4,
  parameter int BUF_DEPTH            = SRAM_READ_LATENCY + 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic issue_valid_i,
  output logic issue_ready_o,
  input  logic [(SRAM_BANKS_ROWS > 1 ?
                 $clog2(SRAM_BANKS_ROWS) : 1)-1:0] issue_row_i,
  input  logic [AXI_ID_WIDTH-1:0] issue_id_i,
  input  logic issue_last_i,
  input  logic [SRAM_BANKS_ROWS*SRAM_BANKS_COLS*
                SRAM_BANK_DATA_WIDTH-1:0] bank_rdata_i,
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
  input  logic [SRAM_BANKS_ROWS*SRAM_BANKS_COLS-1:0] bank_rpar_i,
`endif
  output logic r_valid_o,
  input  logic r_ready_i,
  output logic [SRAM_BANKS_COLS*SRAM_BANK_DATA_WIDTH-1:0] r_data_o,
  output logic [AXI_ID_WIDTH-1:0] r_id_o,
  output logic r_last_o,
  output logic [1:0] r_resp_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0] credits_o
);

  localparam int LAT    = SRAM_READ_LATENCY;
  localparam int COLS   = SRAM_BANKS_COLS;
  localparam int DW     = SRAM_BANK_DATA_WIDTH;
  localparam int BEAT_W = COLS * DW;
  localparam int ROW_W  =
    SRAM_BANKS_ROWS > 1 ? $clog2(SRAM_BANKS_ROWS) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W  =
    BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;

  logic [CNT_W-1:0] credits;
  logic             issue_fire;
  logic             pop;
  logic             push;

  assign issue_ready_o = (credits != '0);
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign pop           = r_valid_o && r_ready_i;
  assign credits_o     = credits;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      credits <= CNT_W'(BUF_DEPTH);
    end else if (issue_fire && !pop) begin
      credits <= credits - CNT_W'(1);
    end else if (pop && !issue_fire) begin
      credits <= credits + CNT_W'(1);
    end
  end

  logic                    tag_vld  [LAT];
  logic [ROW_W-1:0]        tag_row  [LAT];
  logic [AXI_ID_WIDTH-1:0] tag_id   [LAT];
  logic                    tag_last [LAT];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) begin
        tag_vld[i] <= 1'b0;
      end
    end else begin
      tag_vld[0]  <= issue_fire;
      tag_row[0]  <= issue_row_i;
      tag_id[0]   <= issue_id_i;
      tag_last[0] <= issue_last_i;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_row[i]  <= tag_row[i-1];
        tag_id[i]   <= tag_id[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  logic [ROW_W-1:0]  cap_row;
  logic [BEAT_W-1:0] cap_data;
  logic [1:0]        cap_resp;

  assign push     = tag_vld[LAT-1];
  assign cap_row  = tag_row[LAT-1];
  assign cap_data =
    bank_rdata_i[int'(cap_row)*BEAT_W +: BEAT_W];

`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
  always_comb begin
    cap_resp = 2'b00;
    for (int c = 0; c < COLS; c++) begin
      if ((^cap_data[c*DW +: DW]) !=
          bank_rpar_i[int'(cap_row)*COLS + c]) begin
        cap_resp = 2'b10;
      end
    end
  end
`else
  assign cap_resp = 2'b00;
`endif

  logic [BEAT_W-1:0]       mem_data [BUF_DEPTH];
  logic [AXI_ID_WIDTH-1:0] mem_id   [BUF_DEPTH];
  logic                    mem_last [BUF_DEPTH];
  logic [1:0]              mem_resp [BUF_DEPTH];
  logic [PTR_W-1:0]        wptr;
  logic [PTR_W-1:0]        rptr;
  logic [CNT_W-1:0]        count;

  function automatic logic [PTR_W-1:0] ptr_nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cap occupancy, so a push always finds a free slot.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wptr] <= cap_data;
      mem_id[wptr]   <= tag_id[LAT-1];
      mem_last[wptr] <= tag_last[LAT-1];
      mem_resp[wptr] <= cap_resp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_nxt(wptr);
      if (pop)  rptr <= ptr_nxt(rptr);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Outputs are zeroed while empty so stale entries never show.
  assign r_valid_o = (count != '0);
  assign r_data_o  = r_valid_o ? mem_data[rptr] : '0;
  assign r_id_o    = r_valid_o ? mem_id[rptr]   : '0;
  assign r_last_o  = r_valid_o && mem_last[rptr];
  assign r_resp_o  = r_valid_o ? mem_resp[rptr] : 2'b00;

endmodule

// File: tb/tb_axi_sram_rd_pipe.sv
// tb_axi_sram_rd_pipe: randomized and directed bench for
// axi_sram_rd_pipe (ROWS=2, COLS=2, latency 2, depth 4).
module tb_axi_sram_rd_pipe;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int BUF  = 4;
  localparam int BW   = COLS * DW;
  localparam logic [127:0] PAT =
    {32'hA5A50001, 32'h5A5A0002, 32'h5A5A0002, 32'hA5A50001};
  localparam logic [63:0] ROW0 = 64'h5A5A0002_A5A50001;
  localparam logic [63:0] ROW1 = 64'hA5A50001_5A5A0002;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         issue_valid = 1'b0;
  logic         issue_ready;
  logic [0:0]   issue_row = '0;
  logic [3:0]   issue_id = '0;
  logic         issue_last = 1'b0;
  logic [127:0] bank_rdata = '0;
  logic         r_valid;
  logic         r_ready = 1'b0;
  logic [63:0]  r_data;
  logic [3:0]   r_id;
  logic         r_last;
  logic [1:0]   r_resp;
  logic [2:0]   credits;
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
  logic [3:0]   bank_rpar = '0;
  logic [3:0]   par_flip = '0;
  logic [3:0]   phist [int];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bank_mode = 0;

  typedef struct {
    int         c;
    int         row;
    logic [3:0] id;
    logic       last;
  } ent_t;

  ent_t         q[$];
  logic [127:0] hist [int];

  axi_sram_rd_pipe #(
    .SRAM_BANKS_ROWS(ROWS),
    .SRAM_BANKS_COLS(COLS),
    .SRAM_BANK_DATA_WIDTH(DW),
    .SRAM_READ_LATENCY(LAT),
    .AXI_ID_WIDTH(4),
    .BUF_DEPTH(BUF)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .issue_valid_i(issue_valid),
    .issue_ready_o(issue_ready),
    .issue_row_i(issue_row),
    .issue_id_i(issue_id),
    .issue_last_i(issue_last),
    .bank_rdata_i(bank_rdata),
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
    .bank_rpar_i(bank_rpar),
`endif
    .r_valid_o(r_valid),
    .r_ready_i(r_ready),
    .r_data_o(r_data),
    .r_id_o(r_id),
    .r_last_o(r_last),
    .r_resp_o(r_resp),
    .credits_o(credits)
  );

  always #5 clk = ~clk;

  // Reference: a beat issued in cycle c is visible from c+LAT+1,
  // carries the row slice of the bank bus seen in cycle c+LAT, and
  // holds one credit until it is popped.
  function automatic logic m_valid();
    return q.size() > 0 && (q[0].c + LAT + 1 <= cyc);
  endfunction

  function automatic int m_credits();
    return BUF - q.size();
  endfunction

  function automatic logic [63:0] m_data();
    logic [127:0] h;
    h = hist[q[0].c + LAT];
    return h[q[0].row*BW +: BW];
  endfunction

  function automatic logic [1:0] m_resp();
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
    logic [127:0] h;
    logic [3:0]   p;
    int           w;
    h = hist[q[0].c + LAT];
    p = phist[q[0].c + LAT];
    for (int c = 0; c < COLS; c++) begin
      w = q[0].row * COLS + c;
      if ((^h[w*DW +: DW]) != p[w]) return 2'b10;
    end
`endif
    return 2'b00;
  endfunction

  task automatic step();
    logic pop;
    logic acc;
    @(posedge clk);
    hist[cyc] = bank_rdata;
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
    phist[cyc] = bank_rpar;
`endif
    if (!rst_n) begin
      q.delete();
    end else begin
      pop = m_valid() && r_ready;
      acc = issue_valid && (q.size() < BUF);
      if (pop) q.delete(0);
      if (acc) q.push_back('{c: cyc, row: int'(issue_row),
                             id: issue_id, last: issue_last});
    end
    cyc++;
    #1;
    if (bank_mode == 0)
      bank_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    else
      bank_rdata = PAT;
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
    for (int w = 0; w < 4; w++)
      bank_rpar[w] = (^bank_rdata[w*32 +: 32]) ^ par_flip[w];
`endif
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    r_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: valid=%b ready=%b exp 0/1",
               r_valid, issue_ready);
    end
    checks++;
    if (credits !== 3'(BUF)) begin
      errors++;
      $display("FAIL reset_credits: got %0d exp %0d", credits, BUF);
    end
    checks++;
    if (r_data !== '0 || r_id !== '0 || r_last !== 1'b0 ||
        r_resp !== 2'b00) begin
      errors++;
      $display("FAIL reset_outs: data=%h id=%h last=%b resp=%b exp 0",
               r_data, r_id, r_last, r_resp);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    r_ready = 1'b1;
    issue_valid = 1'b1;
    issue_row = 1'b0;
    issue_id = 4'd3;
    issue_last = 1'b1;
    step();
    issue_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (r_valid !== (k == 3)) begin
        errors++;
        $display("FAIL single_valid: t+%0d got %b exp %b",
                 k, r_valid, (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (r_id !== 4'd3 || r_last !== 1'b1 || r_data !== m_data()
            || credits !== 3'(BUF - 1)) begin
          errors++;
          $display("FAIL single_beat: id=%h last=%b data=%h cr=%0d exp 3/1/%h/%0d",
                   r_id, r_last, r_data, credits, m_data(), BUF - 1);
        end
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (credits !== 3'(BUF) || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_credit: got %0d/%b exp %0d/1",
               credits, issue_ready, BUF);
    end
  endtask

  task automatic test_credit_full();
    int acc;
    logic exp_rdy;
    acc = 0;
    r_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1;
      issue_id = i[3:0];
      issue_row = 1'($urandom());
      issue_last = i[0];
      @(negedge clk);
      exp_rdy = (acc < BUF);
      checks++;
      if (issue_ready !== exp_rdy) begin
        errors++;
        $display("FAIL full_ready: i=%0d got %b exp %b",
                 i, issue_ready, exp_rdy);
      end
      if (exp_rdy) acc++;
      step();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b1 || credits !== 3'd0 || r_id !== 4'd0) begin
      errors++;
      $display("FAIL full_state: valid=%b cr=%0d id=%h exp 1/0/0",
               r_valid, credits, r_id);
    end
    step();
    r_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_id !== j[3:0] ||
          r_data !== m_data()) begin
        errors++;
        $display("FAIL full_drain: j=%0d valid=%b id=%h data=%h exp 1/%h/%h",
                 j, r_valid, r_id, r_data, j[3:0], m_data());
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || credits !== 3'(BUF)) begin
      errors++;
      $display("FAIL full_end: valid=%b cr=%0d exp 0/%0d",
               r_valid, credits, BUF);
    end
  endtask

  task automatic test_rows();
    int rowq[$];
    int nb;
    logic [63:0] expd;
    nb = 0;
    bank_mode = 1;
    bank_rdata = PAT;
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
    for (int w = 0; w < 4; w++)
      bank_rpar[w] = ^bank_rdata[w*32 +: 32];
`endif
    r_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      issue_valid = (k < 8);
      issue_row = k[0:0];
      issue_id = k[3:0];
      issue_last = (k == 7);
      @(negedge clk);
      if (issue_valid) rowq.push_back(k % 2);
      if (r_valid === 1'b1) begin
        checks++;
        if (rowq.size() == 0) begin
          errors++;
          $display("FAIL rows_extra: unexpected beat id=%h", r_id);
        end else begin
          expd = (rowq[0] == 0) ? ROW0 : ROW1;
          if (r_data !== expd) begin
            errors++;
            $display("FAIL rows_data: row=%0d got %h exp %h",
                     rowq[0], r_data, expd);
          end
          rowq.delete(0);
        end
        nb++;
      end
      step();
    end
    checks++;
    if (nb != 8) begin
      errors++;
      $display("FAIL rows_count: got %0d exp 8", nb);
    end
    bank_mode = 0;
  endtask

  task automatic test_stream();
    r_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      issue_valid = (k < 16);
      issue_row = 1'($urandom());
      issue_id = 4'($urandom());
      issue_last = 1'($urandom());
      @(negedge clk);
      checks++;
      if (r_valid !== (k >= 3 && k < 19)) begin
        errors++;
        $display("FAIL stream_valid: k=%0d got %b exp %b",
                 k, r_valid, (k >= 3 && k < 19));
      end
      checks++;
      if (credits !== 3'(m_credits()) ||
          (k >= 3 && k <= 16 && credits !== 3'(BUF - LAT - 1))) begin
        errors++;
        $display("FAIL stream_credits: k=%0d got %0d exp %0d",
                 k, credits, m_credits());
      end
      if (m_valid()) begin
        checks++;
        if (r_data !== m_data() || r_id !== q[0].id ||
            r_last !== q[0].last) begin
          errors++;
          $display("FAIL stream_beat: k=%0d got %h/%h/%b exp %h/%h/%b",
                   k, r_data, r_id, r_last, m_data(), q[0].id,
                   q[0].last);
        end
      end
      step();
    end
  endtask

  task automatic test_same_cycle();
    r_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      issue_valid = (k < 3);
      issue_id = 4'(8 + k);
      issue_row = 1'($urandom());
      issue_last = 1'b0;
      step();
    end
    @(negedge clk);
    checks++;
    if (credits !== 3'd1 || r_valid !== 1'b1) begin
      errors++;
      $display("FAIL same_pre: cr=%0d valid=%b exp 1/1",
               credits, r_valid);
    end
    issue_valid = 1'b1;
    issue_id = 4'd11;
    r_ready = 1'b1;
    step();
    issue_valid = 1'b0;
    r_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (credits !== 3'd1 || issue_ready !== 1'b1 ||
        r_valid !== 1'b1 || r_id !== 4'd9) begin
      errors++;
      $display("FAIL same_post: cr=%0d rdy=%b valid=%b id=%h exp 1/1/1/9",
               credits, issue_ready, r_valid, r_id);
    end
    for (int k = 0; k < 3; k++) step();
    r_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_id !== 4'(9 + j) ||
          r_data !== m_data()) begin
        errors++;
        $display("FAIL same_drain: j=%0d valid=%b id=%h exp 1/%h",
                 j, r_valid, r_id, 4'(9 + j));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || credits !== 3'(BUF)) begin
      errors++;
      $display("FAIL same_end: valid=%b cr=%0d exp 0/%0d",
               r_valid, credits, BUF);
    end
  endtask

  task automatic test_reset_midflight();
    r_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue_valid = (k != 1);
      issue_id = 4'(k);
      issue_row = 1'($urandom());
      step();
    end
    issue_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b1 || credits !== 3'(BUF - 3)) begin
      errors++;
      $display("FAIL mid_pre: valid=%b cr=%0d exp 1/%0d",
               r_valid, credits, BUF - 3);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r_ready = 1'($urandom());
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b0 || credits !== 3'(BUF)) begin
        errors++;
        $display("FAIL mid_post: k=%0d valid=%b cr=%0d exp 0/%0d",
                 k, r_valid, credits, BUF);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      issue_valid = ($urandom() % 3) != 0;
      r_ready = ($urandom() % 4) != 0;
      issue_row = 1'($urandom());
      issue_id = 4'($urandom());
      issue_last = 1'($urandom());
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
      par_flip = (($urandom() % 8) == 0) ? 4'(1 << ($urandom() % 4)) : 4'd0;
`endif
      @(negedge clk);
      checks++;
      if (r_valid !== m_valid() || issue_ready !== (q.size() < BUF) ||
          credits !== 3'(m_credits())) begin
        errors++;
        $display("FAIL rnd_ctrl: k=%0d valid=%b rdy=%b cr=%0d exp %b/%b/%0d",
                 k, r_valid, issue_ready, credits, m_valid(),
                 (q.size() < BUF), m_credits());
      end
      if (m_valid()) begin
        checks++;
        if (r_data !== m_data() || r_id !== q[0].id ||
            r_last !== q[0].last || r_resp !== m_resp()) begin
          errors++;
          $display("FAIL rnd_beat: k=%0d got %h/%h/%b/%b exp %h/%h/%b/%b",
                   k, r_data, r_id, r_last, r_resp, m_data(), q[0].id,
                   q[0].last, m_resp());
        end
      end
      step();
    end
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
    par_flip = '0;
`endif
    idle(10);
  endtask

`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
  task automatic test_parity();
    logic [1:0] er;
    r_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      issue_valid = (k < 3);
      issue_row = 1'b1;
      issue_id = 4'(k);
      par_flip = (k == 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (k >= 3 && k <= 5) begin
        er = (k == 4) ? 2'b10 : 2'b00;
        checks++;
        if (r_valid !== 1'b1 || r_resp !== er ||
            r_data !== m_data()) begin
          errors++;
          $display("FAIL parity_resp: k=%0d valid=%b resp=%b exp 1/%b",
                   k, r_valid, r_resp, er);
        end
      end
      step();
    end
    par_flip = '0;
  endtask
`endif

  initial begin
    bank_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    test_reset();
    test_single();
    idle(2);
    test_credit_full();
    idle(2);
    test_rows();
    idle(2);
    test_stream();
    idle(2);
    test_same_cycle();
    idle(2);
    test_reset_midflight();
    idle(2);
    test_random();
`ifdef AXI_SRAM_RD_PIPE_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
